seg_bcd_display: RTL

- Downstream consumer of the processor core's 16-bit display value.
- Replaces the combinational divide/modulo digit path with a sequential binary-to-BCD converter using shift-add-3 (double dabble).
- Registers four active-low 7-segment digit outputs (HEX3..HEX0) plus an overflow flag.
- The core presents a value with a valid/ready handshake; the block holds the last converted value until the next one arrives.

---
 rtl/seg_pkg.sv | 29 ++
 rtl/seg_digit_decode.sv | 27 ++
 rtl/seg_bcd_display.sv | 129 ++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and segment constants for the BCD 7-segment display block.
// Encoding: active-low, bit0=seg a .. bit6=seg g.
package seg_pkg;

  localparam int BCD_DIGITS = 5;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LOAD
  } state_t;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/seg_digit_decode.sv
// Combinational BCD nibble to active-low 7-segment decoder.
// Non-decimal nibbles render blank.
module seg_digit_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nib)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_bcd_display.sv
// Sequential double-dabble binary-to-BCD converter driving four 7-seg digits.
// Optional SEG_LEADING_ZERO_BLANK_EN blanks leading zeros on hex3..hex1.
module seg_bcd_display
  import seg_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_ITER = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_valid,
  input  logic [DATA_W-1:0] disp_data,
  output logic              disp_ready,
  input  logic              disp_clear,
  output logic              busy,
  output logic              ovf,
  output logic [6:0]        hex3,
  output logic [6:0]        hex2,
  output logic [6:0]        hex1,
  output logic [6:0]        hex0
);

  localparam int SH_W = 4 * BCD_DIGITS + DATA_W;

  state_t            r_state;
  logic [4:0]        r_cnt;
  logic [SH_W-1:0]   r_sh;
  logic [SH_W-1:0]   w_adj;
  logic [6:0]        r_hex3, r_hex2, r_hex1, r_hex0;
  logic              r_ovf, r_busy, r_ready;
  logic [6:0]        w_seg3, w_seg2, w_seg1, w_seg0;
  logic [3:0]        w_nib4, w_nib3, w_nib2, w_nib1, w_nib0;
  logic              w_ovf;
  logic              w_lz3, w_lz2, w_lz1;

  assign w_nib0 = r_sh[DATA_W +: 4];
  assign w_nib1 = r_sh[DATA_W+4 +: 4];
  assign w_nib2 = r_sh[DATA_W+8 +: 4];
  assign w_nib3 = r_sh[DATA_W+12 +: 4];
  assign w_nib4 = r_sh[DATA_W+16 +: 4];
  assign w_ovf  = (w_nib4 != 4'd0);

  always_comb begin
    w_adj = r_sh;
    for (int d = 0; d < BCD_DIGITS; d++)
      w_adj[DATA_W+4*d +: 4] = add3(r_sh[DATA_W+4*d +: 4]);
  end

  seg_digit_decode u_dec0 (.i_nib(w_nib0), .o_seg(w_seg0));
  seg_digit_decode u_dec1 (.i_nib(w_nib1), .o_seg(w_seg1));
  seg_digit_decode u_dec2 (.i_nib(w_nib2), .o_seg(w_seg2));
  seg_digit_decode u_dec3 (.i_nib(w_nib3), .o_seg(w_seg3));

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Blanking chain stops at the first non-zero digit; overflow shows all.
  assign w_lz3 = !w_ovf && (w_nib3 == 4'd0);
  assign w_lz2 = w_lz3 && (w_nib2 == 4'd0);
  assign w_lz1 = w_lz2 && (w_nib1 == 4'd0);
`else
  assign w_lz3 = 1'b0;
  assign w_lz2 = 1'b0;
  assign w_lz1 = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_hex3  <= SEG_BLANK;
      r_hex2  <= SEG_BLANK;
      r_hex1  <= SEG_BLANK;
      r_hex0  <= SEG_BLANK;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      if (disp_clear) begin
        r_hex3 <= SEG_BLANK;
        r_hex2 <= SEG_BLANK;
        r_hex1 <= SEG_BLANK;
        r_hex0 <= SEG_BLANK;
        r_ovf  <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (disp_valid) begin
            r_sh    <= {{(4*BCD_DIGITS){1'b0}}, disp_data};
            r_cnt   <= '0;
            r_state <= CONV;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
          end
        end
        CONV: begin
          r_sh  <= {w_adj[SH_W-2:0], 1'b0};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'(NUM_ITER - 1))
            r_state <= LOAD;
        end
        LOAD: begin
          // Placed after the clear so a coincident clear loses.
          r_hex3  <= w_lz3 ? SEG_BLANK : w_seg3;
          r_hex2  <= w_lz2 ? SEG_BLANK : w_seg2;
          r_hex1  <= w_lz1 ? SEG_BLANK : w_seg1;
          r_hex0  <= w_seg0;
          r_ovf   <= w_ovf;
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign disp_ready = r_ready;
  assign busy       = r_busy;
  assign ovf        = r_ovf;
  assign hex3       = r_hex3;
  assign hex2       = r_hex2;
  assign hex1       = r_hex1;
  assign hex0       = r_hex0;

endmodule
